uart_rx: RTL and testbench



---
 rtl/uart_rx_pkg.sv | 18 +
 rtl/uart_rx_if.sv | 26 ++
 rtl/uart_sync2.sv | 35 +++
 rtl/uart_rx.sv | 131 +++++++++++++
 tb/tb_uart_rx.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared uart FSM encodings and default frame constants
// Purpose: state encoding shared by uart_rx (and the future uart_tx),
//          plus the default 8N1 / 16x oversampling constants.
// Ports:   none (package).
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int UART_DBIT    = 8;
  localparam int UART_OVS     = 16;
  localparam int UART_SB_TICK = 16;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial-side inputs and parallel-side outputs of the receiver
// Purpose: bundles the rx line, oversampling tick and the received-byte outputs.
// Ports:   rx, s_tick (toward receiver); dout, rx_done, frame_err, rx_busy (from receiver).
//          master = line/tick source and consumer, slave = uart_rx.
interface uart_rx_if import uart_rx_pkg::*; #(
  parameter int DBIT = UART_DBIT
) ();

  logic            rx;
  logic            s_tick;
  logic [DBIT-1:0] dout;
  logic            rx_done;
  logic            frame_err;
  logic            rx_busy;

  modport master (
    output rx, s_tick,
    input  dout, rx_done, frame_err, rx_busy
  );

  modport slave (
    input  rx, s_tick,
    output dout, rx_done, frame_err, rx_busy
  );

endinterface

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer with a selectable reset value
// Purpose: brings an asynchronous input into the clk domain (2 clk latency).
// Ports:   clk, rst (sync, active-high), rst_val (value loaded on reset),
//          d (async input), q (synchronized output).
module uart_sync2 import uart_rx_pkg::*; #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] rst_val,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= rst_val;
      sync_q <= rst_val;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1-style serial receiver driven by an oversampling tick
// Purpose: detects the start bit, samples each data bit mid-period (LSB first),
//          checks the stop bit and presents the byte with a one-clk done strobe.
// Ports:   clk, rst (sync, active-high); bus (uart_rx_if.slave):
//          rx, s_tick in; dout, rx_done, frame_err, rx_busy out.
module uart_rx import uart_rx_pkg::*; #(
  parameter int DBIT    = UART_DBIT,
  parameter int OVS     = UART_OVS,
  parameter int SB_TICK = UART_SB_TICK
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.slave  bus
);

  localparam int TW = $clog2((OVS > SB_TICK) ? OVS : SB_TICK);
  localparam int BW = $clog2(DBIT);

  localparam logic [TW-1:0] HALF_LAST = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(OVS - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] DBIT_LAST = BW'(DBIT - 1);

  logic rx_s;

  uart_sync2 #(.W(1)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .rst_val (1'b1),
    .d       (bus.rx),
    .q       (rx_s)
  );

  uart_state_e     state_q, state_d;
  logic [TW-1:0]   tick_q,  tick_d;
  logic [BW-1:0]   bit_q,   bit_d;
  logic [DBIT-1:0] shreg_q, shreg_d;
  logic [DBIT-1:0] dout_q,  dout_d;
  logic            done_q,  done_d;
  logic            ferr_q,  ferr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      // Start detection is not tick-qualified, so a new frame can begin
      // the very first clk after STOP returns here.
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          tick_d  = '0;
        end
      end
      START: begin
        if (bus.s_tick) begin
          if (tick_q == HALF_LAST) begin
            // Line back high at mid start bit: a glitch, drop it silently.
            if (!rx_s) begin
              state_d = DATA;
              tick_d  = '0;
              bit_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (bus.s_tick) begin
          if (tick_q == BIT_LAST) begin
            tick_d  = '0;
            shreg_d = {rx_s, shreg_q[DBIT-1:1]};
            if (bit_q == DBIT_LAST) begin
              state_d = STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (bus.s_tick) begin
          if (tick_q == STOP_LAST) begin
            state_d = IDLE;
            dout_d  = shreg_q;
            done_d  = 1'b1;
            ferr_d  = ~rx_s;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.dout      = dout_q;
  assign bus.rx_done   = done_q;
  assign bus.frame_err = ferr_q;
  assign bus.rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx (1 and 2 stop-bit instances)
module tb_uart_rx;
  import uart_rx_pkg::*;

  typedef struct {
    logic [7:0] d;
    logic       e;
    int         due;
  } frame_t;

  typedef struct {
    int s;
    int e;
  } win_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  frame_t exp1[$];
  frame_t exp2[$];
  frame_t cap1[$];
  frame_t cap2[$];
  win_t   win1[$];
  logic [7:0] dout_exp1 = 8'h00;
  logic [7:0] dout_exp2 = 8'h00;
  int   last_k0;
  int   k0_a5;

  uart_rx_if #(.DBIT(8)) if16 ();
  uart_rx_if #(.DBIT(8)) if32 ();

  uart_rx #(.DBIT(8), .OVS(16), .SB_TICK(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (if16)
  );

  uart_rx #(.DBIT(8), .OVS(16), .SB_TICK(32)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (if32)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // One tick every 4 clk: s_tick is seen by the posedges where cyc % 4 == 1.
  initial begin
    if16.s_tick = 1'b0;
    if32.s_tick = 1'b0;
    forever begin
      @(negedge clk);
      if16.s_tick = (cyc % 4 == 0);
      if32.s_tick = (cyc % 4 == 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h cyc=%0d", name, got, want, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic align4();
    while (cyc % 4 != 0) @(negedge clk);
  endtask

  // Frame timing with a 64-clk bit and the start edge driven at cyc k0 (k0 % 4 == 0):
  // rx_s falls 2 clk later, START entered at k0+3, mid-start tick k0+33,
  // data samples every 64 clk to k0+545, last stop tick k0+609 (+64 for 2 stop bits).
  task automatic send_frame(input logic [7:0] data, input logic stop_val, input bit both);
    logic [9:0] bits;
    align4();
    last_k0 = cyc;
    bits = {stop_val, data, 1'b0};
    exp1.push_back('{data, ~stop_val, last_k0 + 609});
    win1.push_back('{last_k0 + 3, last_k0 + 608});
    if (both) exp2.push_back('{data, ~stop_val, last_k0 + 673});
    if (!stop_val) begin
      // Line still low when the receiver returns to IDLE: it restarts at k0+610,
      // its mid-start sample at k0+641 still sees the low stop bit, and the
      // following idle-high line is read as an all-ones byte with a good stop.
      exp1.push_back('{8'hFF, 1'b0, last_k0 + 1217});
      win1.push_back('{last_k0 + 610, last_k0 + 1216});
    end
    for (int i = 0; i < 10; i++) begin
      if16.rx = bits[i];
      if (both) if32.rx = bits[i];
      idle(64);
    end
    if16.rx = 1'b1;
    if32.rx = 1'b1;
  endtask

  // Per-cycle comparison against the frame scoreboard and busy windows.
  initial begin
    logic busy_exp;
    forever begin
      @(posedge clk);
      #1;
      if (exp1.size() > 0 && exp1[0].due == cyc) begin
        chk("done1", if16.rx_done, 1);
        chk("dout1", if16.dout, exp1[0].d);
        chk("ferr1", if16.frame_err, exp1[0].e);
        dout_exp1 = exp1[0].d;
        void'(exp1.pop_front());
      end else begin
        chk("done1_quiet", if16.rx_done, 0);
        chk("ferr1_quiet", if16.frame_err, 0);
        chk("dout1_hold", if16.dout, dout_exp1);
      end
      if (exp2.size() > 0 && exp2[0].due == cyc) begin
        chk("done2", if32.rx_done, 1);
        chk("dout2", if32.dout, exp2[0].d);
        chk("ferr2", if32.frame_err, exp2[0].e);
        dout_exp2 = exp2[0].d;
        void'(exp2.pop_front());
      end else begin
        chk("done2_quiet", if32.rx_done, 0);
        chk("ferr2_quiet", if32.frame_err, 0);
        chk("dout2_hold", if32.dout, dout_exp2);
      end
      busy_exp = 1'b0;
      foreach (win1[i]) if (cyc >= win1[i].s && cyc <= win1[i].e) busy_exp = 1'b1;
      chk("busy1", if16.rx_busy, busy_exp);
      if (if16.rx_done === 1'b1) cap1.push_back('{if16.dout, if16.frame_err, cyc});
      if (if32.rx_done === 1'b1) cap2.push_back('{if32.dout, if32.frame_err, cyc});
    end
  end

  initial begin
    logic [7:0] pin_d [8];
    logic       pin_e [8];
    int k;
    pin_d = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'hFF, 8'h55, 8'h7E, 8'h11};
    pin_e = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    if16.rx = 1'b1;
    if32.rx = 1'b1;
    idle(4);
    rst = 1'b0;
    chk("rst_dout", if16.dout, 0);
    chk("rst_done", if16.rx_done, 0);
    chk("rst_ferr", if16.frame_err, 0);
    chk("rst_busy", if16.rx_busy, 0);
    chk("rst_busy2", if32.rx_busy, 0);
    idle(20);

    send_frame(8'hA5, 1'b1, 1'b0);
    k0_a5 = last_k0;
    idle(50);

    // Glitch: 20 clk low, mid-start sample at k+33 sees the line high again.
    align4();
    k = cyc;
    win1.push_back('{k + 3, k + 32});
    if16.rx = 1'b0;
    idle(20);
    if16.rx = 1'b1;
    idle(80);

    send_frame(8'h3C, 1'b0, 1'b0);
    idle(700);

    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1, 1'b0);
    idle(50);

    // 0x81 aborted by a 1-clk reset half-way through bit 4; sender also goes idle.
    align4();
    k = cyc;
    win1.push_back('{k + 3, k + 100000});
    if16.rx = 1'b0; idle(64);
    if16.rx = 1'b1; idle(64);
    if16.rx = 1'b0; idle(64);
    if16.rx = 1'b0; idle(64);
    if16.rx = 1'b0; idle(64);
    if16.rx = 1'b0; idle(32);
    rst = 1'b1;
    if16.rx = 1'b1;
    dout_exp1 = 8'h00;
    win1[win1.size() - 1].e = cyc;
    idle(1);
    rst = 1'b0;
    idle(100);

    send_frame(8'h7E, 1'b1, 1'b0);
    idle(50);

    send_frame(8'h11, 1'b1, 1'b1);
    idle(200);

    chk("exp1_drained", exp1.size(), 0);
    chk("exp2_drained", exp2.size(), 0);
    chk("cap1_count", cap1.size(), 8);
    chk("cap2_count", cap2.size(), 1);
    for (int i = 0; i < 8; i++) begin
      if (i < cap1.size()) begin
        chk("pin_dout", cap1[i].d, pin_d[i]);
        chk("pin_ferr", cap1[i].e, pin_e[i]);
      end
    end
    if (cap1.size() > 0) chk("pin_a5_latency", cap1[0].due - k0_a5, 609);
    if (cap2.size() > 0 && cap1.size() == 8) begin
      chk("pin_dout_sb32", cap2[0].d, 8'h11);
      chk("pin_sb32_delay", cap2[0].due - cap1[7].due, 64);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
